// File: rtl/sram_sample_streamer.sv
// Streams one stored note sample per codec tick out of board SRAM.
// Loops or ends playback; emits silence while idle.
module sram_sample_streamer #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 16,
  parameter int READ_WAIT = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              sample_clk,
  input  logic              trigger,
  input  logic              stop,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              loop_en,
  input  logic [3:0]        atten,
  input  logic [DATA_W-1:0] sram_data,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [DATA_W-1:0] audio_data,
  output logic              sample_valid,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_READ
  } state_t;

  localparam logic [2:0]        LP_WAIT = 3'(READ_WAIT);
  localparam logic [ADDR_W-1:0] LP_ONE  = ADDR_W'(1);

  state_t              r_state, w_state;
  logic                r_s1, r_s2, r_s3, r_tick;
  logic [ADDR_W-1:0]   r_ptr, w_ptr;
  logic [ADDR_W-1:0]   r_start, w_start;
  logic [ADDR_W-1:0]   r_end, w_end;
  logic                r_loop, w_loop;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic                r_ce_n, w_ce_n;
  logic [DATA_W-1:0]   r_audio, w_audio;
  logic                r_valid, w_valid;
  logic                r_done, w_done;
  logic                r_ovr, w_ovr;
  logic [2:0]          r_wait, w_wait;
  logic signed [DATA_W-1:0] w_samp;
  logic                w_trig_ok;

  assign w_samp    = $signed(sram_data) >>> atten;
  assign w_trig_ok = trigger && (end_addr >= start_addr);

  // Sample-clock synchronizer and registered rising-edge tick
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_s1   <= sample_clk;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_tick <= r_s2 & ~r_s3;
    end
  end

  // Playback state and datapath registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_start <= '0;
      r_end   <= '0;
      r_loop  <= 1'b0;
      r_addr  <= '0;
      r_ce_n  <= 1'b1;
      r_audio <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
      r_wait  <= '0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_start <= w_start;
      r_end   <= w_end;
      r_loop  <= w_loop;
      r_addr  <= w_addr;
      r_ce_n  <= w_ce_n;
      r_audio <= w_audio;
      r_valid <= w_valid;
      r_done  <= w_done;
      r_ovr   <= w_ovr;
      r_wait  <= w_wait;
    end
  end

  // Next state: restart beats stop, stop beats normal sequencing
  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_start = r_start;
    w_end   = r_end;
    w_loop  = r_loop;
    w_addr  = r_addr;
    w_ce_n  = r_ce_n;
    w_audio = r_audio;
    w_valid = 1'b0;
    w_done  = 1'b0;
    w_ovr   = r_ovr;
    w_wait  = r_wait;
    if (w_trig_ok) begin
      w_start = start_addr;
      w_end   = end_addr;
      w_loop  = loop_en;
      w_ptr   = start_addr;
      w_ovr   = 1'b0;
      w_ce_n  = 1'b1;
      w_wait  = '0;
      w_state = S_WAIT;
    end else if (stop && r_state != S_IDLE) begin
      w_state = S_IDLE;
      w_ce_n  = 1'b1;
      w_audio = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (r_tick) begin
            w_audio = '0;
            w_valid = 1'b1;
          end
        end
        S_WAIT: begin
          if (r_tick) begin
            w_addr  = r_ptr;
            w_ce_n  = 1'b0;
            w_wait  = '0;
            w_state = S_READ;
          end
        end
        S_READ: begin
          if (r_tick) w_ovr = 1'b1;
          if (r_wait == LP_WAIT) begin
            w_audio = w_samp;
            w_valid = 1'b1;
            w_ce_n  = 1'b1;
            if (r_ptr != r_end) begin
              w_ptr   = r_ptr + LP_ONE;
              w_state = S_WAIT;
            end else if (r_loop) begin
              w_ptr   = r_start;
              w_state = S_WAIT;
            end else begin
              w_done  = 1'b1;
              w_state = S_IDLE;
            end
          end else begin
            w_wait = r_wait + 3'd1;
          end
        end
        default: w_state = S_IDLE;
      endcase
    end
  end

  assign sram_addr    = r_addr;
  assign sram_ce_n    = r_ce_n;
  assign sram_oe_n    = r_ce_n;
  assign sram_we_n    = 1'b1;
  assign audio_data   = r_audio;
  assign sample_valid = r_valid;
  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
  assign overrun      = r_ovr;

endmodule

// File: tb/tb_sram_sample_streamer.sv
// Scoreboard bench for sram_sample_streamer.
// Directed stimulus; monitor checks every sample_valid.
module tb_sram_sample_streamer;

  logic        Clk;
  logic        Reset_n;
  logic        sample_clk;
  logic        trigger;
  logic        stop;
  logic [19:0] start_addr;
  logic [19:0] end_addr;
  logic        loop_en;
  logic [3:0]  atten;
  logic [15:0] sram_data;
  logic [19:0] sram_addr;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [15:0] audio_data;
  logic        sample_valid;
  logic        busy;
  logic        done;
  logic        overrun;

  typedef struct {
    logic [15:0] d;
    logic        dn;
    int          c;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic force8k = 1'b0;

  sram_sample_streamer #(
    .ADDR_W(20), .DATA_W(16), .READ_WAIT(1)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .sample_clk(sample_clk),
    .trigger(trigger), .stop(stop),
    .start_addr(start_addr), .end_addr(end_addr),
    .loop_en(loop_en), .atten(atten), .sram_data(sram_data),
    .sram_addr(sram_addr), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .audio_data(audio_data), .sample_valid(sample_valid),
    .busy(busy), .done(done), .overrun(overrun)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  assign sram_data = force8k ? 16'h8000 : (sram_addr[15:0] + 16'h0100);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (Reset_n && sample_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got data %0h want none",
                 audio_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sample_data", {16'd0, audio_data}, {16'd0, e.d});
        chk("sample_done", {31'd0, done}, {31'd0, e.dn});
        chk("sample_cycle", cyc, e.c);
      end
    end else if (Reset_n && done) begin
      checks++;
      errors++;
      $display("FAIL stray_done: got 1 want 0");
    end
  end

  task automatic push(input logic [15:0] d, input logic dn,
                      input int lat);
    exp_t e;
    e.d  = d;
    e.dn = dn;
    e.c  = cyc + lat;
    q.push_back(e);
  endtask

  task automatic tick_exp(input logic [15:0] d, input logic dn,
                          input int lat);
    @(posedge Clk);
    #1;
    push(d, dn, lat);
    sample_clk = 1'b1;
    repeat (4) @(posedge Clk);
    #1 sample_clk = 1'b0;
    repeat (5) @(posedge Clk);
  endtask

  task automatic trig(input logic [19:0] s, input logic [19:0] e,
                      input logic lp);
    @(posedge Clk);
    #1;
    start_addr = s;
    end_addr   = e;
    loop_en    = lp;
    trigger    = 1'b1;
    @(posedge Clk);
    #1 trigger = 1'b0;
  endtask

  task automatic do_stop();
    @(posedge Clk);
    #1 stop = 1'b1;
    @(posedge Clk);
    #1 stop = 1'b0;
  endtask

  initial begin
    Reset_n    = 1'b0;
    sample_clk = 1'b0;
    trigger    = 1'b0;
    stop       = 1'b0;
    start_addr = '0;
    end_addr   = '0;
    loop_en    = 1'b0;
    atten      = 4'd0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ce_n", {31'd0, sram_ce_n}, 32'd1);
    chk("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
    chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst_addr", {12'd0, sram_addr}, 32'd0);
    chk("rst_audio", {16'd0, audio_data}, 32'd0);
    chk("rst_valid", {31'd0, sample_valid}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    @(posedge Clk);
    #1 Reset_n = 1'b1;

    // one-shot 2..4, then idle silence
    trig(20'd2, 20'd4, 1'b0);
    chk("busy_after_trig", {31'd0, busy}, 32'd1);
    tick_exp(16'h0102, 1'b0, 6);
    tick_exp(16'h0103, 1'b0, 6);
    tick_exp(16'h0104, 1'b1, 6);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    tick_exp(16'h0000, 1'b0, 4);

    // looping 2..4
    trig(20'd2, 20'd4, 1'b1);
    tick_exp(16'h0102, 1'b0, 6);
    tick_exp(16'h0103, 1'b0, 6);
    tick_exp(16'h0104, 1'b0, 6);
    tick_exp(16'h0102, 1'b0, 6);
    tick_exp(16'h0103, 1'b0, 6);
    do_stop();
    chk("busy_after_stop", {31'd0, busy}, 32'd0);

    // attenuation of a negative sample, single-sample note
    force8k = 1'b1;
    atten   = 4'd2;
    trig(20'd10, 20'd10, 1'b0);
    tick_exp(16'hE000, 1'b1, 6);
    force8k = 1'b0;
    atten   = 4'd0;

    // reversed range is ignored
    trig(20'd5, 20'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("bad_trig_busy", {31'd0, busy}, 32'd0);
      chk("bad_trig_oe_n", {31'd0, sram_oe_n}, 32'd1);
      @(posedge Clk);
      #1;
    end

    // second tick lands in the last READ cycle
    trig(20'd2, 20'd4, 1'b0);
    @(posedge Clk);
    #1;
    push(16'h0102, 1'b0, 6);
    sample_clk = 1'b1;
    @(posedge Clk);
    #1 sample_clk = 1'b0;
    @(posedge Clk);
    #1 sample_clk = 1'b1;
    repeat (3) @(posedge Clk);
    #1 sample_clk = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    tick_exp(16'h0103, 1'b0, 6);
    do_stop();
    trig(20'd2, 20'd4, 1'b0);
    chk("overrun_clr", {31'd0, overrun}, 32'd0);
    do_stop();

    // stop during READ
    trig(20'd2, 20'd4, 1'b0);
    @(posedge Clk);
    #1 sample_clk = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    chk("read_oe_n", {31'd0, sram_oe_n}, 32'd0);
    stop = 1'b1;
    @(posedge Clk);
    #1 stop = 1'b0;
    chk("stop_audio", {16'd0, audio_data}, 32'd0);
    chk("stop_busy", {31'd0, busy}, 32'd0);
    chk("stop_oe_n", {31'd0, sram_oe_n}, 32'd1);
    sample_clk = 1'b0;
    repeat (6) @(posedge Clk);
    #1;

    // trigger wins over stop
    start_addr = 20'd2;
    end_addr   = 20'd4;
    loop_en    = 1'b0;
    trigger    = 1'b1;
    stop       = 1'b1;
    @(posedge Clk);
    #1;
    trigger = 1'b0;
    stop    = 1'b0;
    chk("trig_stop_busy", {31'd0, busy}, 32'd1);
    do_stop();

    // async reset in the middle of a READ
    trig(20'd2, 20'd4, 1'b0);
    @(posedge Clk);
    #1 sample_clk = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    chk("pre_rst_oe_n", {31'd0, sram_oe_n}, 32'd0);
    #2 Reset_n = 1'b0;
    #1;
    chk("arst_oe_n", {31'd0, sram_oe_n}, 32'd1);
    chk("arst_ce_n", {31'd0, sram_ce_n}, 32'd1);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_addr", {12'd0, sram_addr}, 32'd0);
    sample_clk = 1'b0;
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    repeat (8) @(posedge Clk);
    #1;
    chk("arst_idle_busy", {31'd0, busy}, 32'd0);

    chk("queue_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_sample_streamer.md
Name: sram_sample_streamer

Overview:
- Plays one stored note sample out of the board SRAM, one 16-bit word per codec sample period.
- Sits between the note-address control (which supplies start/end addresses and trigger/stop) and the audio codec driver (which consumes audio_data).
- Owns the SRAM read handshake, loops or ends playback, and emits silence when idle so the codec always receives a word per period.

Parameters:
- ADDR_W, 20, SRAM word-address width.
- DATA_W, 16, sample width (two's complement).
- READ_WAIT, 1, extra Clk cycles the SRAM read is held before data is sampled (0..7).

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset_n  in  1  asynchronous, active-low reset.
- sample_clk  in  1  codec sample-rate clock (LRCK domain); synchronized internally.
- trigger  in  1  one-cycle pulse: start playback using start_addr/end_addr/loop_en.
- stop  in  1  one-cycle pulse: abort playback.
- start_addr  in  ADDR_W  first sample address; sampled on trigger.
- end_addr  in  ADDR_W  last sample address, inclusive; sampled on trigger.
- loop_en  in  1  1 = wrap to start_addr after end_addr; sampled on trigger.
- atten  in  4  arithmetic right-shift applied to each sample; sampled at each latch.
- sram_data  in  DATA_W  SRAM read data bus (tri-state handled at top level).
- sram_addr  out  ADDR_W  SRAM address.
- sram_ce_n  out  1  SRAM chip enable, active low.
- sram_oe_n  out  1  SRAM output enable, active low.
- sram_we_n  out  1  SRAM write enable; constant 1.
- audio_data  out  DATA_W  current sample to the codec driver.
- sample_valid  out  1  one-cycle pulse when audio_data updates.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse when non-looping playback finishes.
- overrun  out  1  sticky: a tick arrived during a read.

Behaviour:
- Reset (async assert, sync deassert) sets these values. State: IDLE. sram_addr: 0. sram_ce_n: 1. sram_oe_n: 1. sram_we_n: 1. audio_data: 0. sample_valid: 0. busy: 0. done: 0. overrun: 0. Pointer: 0. Synchronizer flops: 0.
- Tick generation:
  - sample_clk passes through a 2-flop synchronizer plus a rising-edge detector, producing a one-Clk tick.
  - The tick pulse is high in the 3rd Clk cycle after the sample_clk rise is first captured.
- States are IDLE, WAIT_TICK and READ.
- IDLE:
  - On tick: audio_data <= 0 and sample_valid pulses one cycle after the tick (silence stream).
  - On trigger with end_addr >= start_addr: latch the addresses and loop_en, ptr <= start_addr, clear overrun, go to WAIT_TICK.
  - On trigger with end_addr < start_addr: ignored; stay IDLE; no done pulse.
- WAIT_TICK:
  - On tick: go to READ. sram_addr <= ptr, and ce_n/oe_n drop to 0 at the same edge.
  - READ is held for READ_WAIT+1 cycles.
- READ:
  - The Clk edge ending the last READ cycle samples sram_data and sets audio_data <= $signed(sram_data) >>> atten.
  - At that same edge sample_valid pulses and ce_n/oe_n return to 1.
  - Latency: a tick at cycle T gives sample_valid/audio_data in cycle T+2+READ_WAIT.
  - Pointer update at the same edge:
    - ptr != end: ptr <= ptr+1, go to WAIT_TICK.
    - ptr == end and loop_en: ptr <= start, go to WAIT_TICK.
    - ptr == end and !loop_en: done pulses with that sample_valid, go to IDLE.
  - end_addr = 2^ADDR_W-1 never increments past the top; the pointer never wraps through 0.
  - A tick during READ sets overrun. The tick is dropped; the read completes normally.
- busy = 1 in WAIT_TICK and READ.
- stop (any non-IDLE state):
  - Next edge: state IDLE, ce_n/oe_n = 1, audio_data <= 0.
  - No sample_valid pulse for that read; no done pulse.
- trigger in WAIT_TICK or READ:
  - Restarts: abort any read (ce_n/oe_n = 1), latch the new addresses, ptr <= new start, clear overrun, go to WAIT_TICK.
  - audio_data holds its last value.
- Simultaneous events:
  - trigger and stop in the same cycle: trigger wins.
  - trigger and tick in the same cycle in WAIT_TICK: the restart wins and the tick is dropped.
- A single-sample note (start == end) plays once, or repeats every tick if loop_en = 1.

Test Plan:
- Reset mid-READ (Reset_n low 1 cycle) -> outputs take reset values immediately (async), even with oe_n low.
- READ_WAIT=1, SRAM model (data = addr+0x100), start=2, end=4, loop_en=0, atten=0, trigger, 3 ticks:
  - audio_data = 0x0102, 0x0103, 0x0104, each sample_valid 3 cycles after its tick.
  - done coincides with the 3rd sample_valid; busy then drops.
  - A 4th tick gives audio_data = 0 with sample_valid.
- Same setup with loop_en=1, 5 ticks -> samples 0x0102, 0x0103, 0x0104, 0x0102, 0x0103; no done.
- sram_data = 0x8000, atten=2 -> audio_data = 0xE000.
- start=5, end=3, trigger -> busy stays 0 and sram_oe_n stays 1; no done.
- Extra tick injected during READ -> overrun = 1 and the sample count is unchanged; the next trigger clears overrun.
- stop during READ -> audio_data = 0 next cycle, no sample_valid or done.
- trigger+stop in the same cycle -> playback starts (busy = 1).
